// File: rtl/seq_drv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_drv_pkg                                                     |
// | Purpose  : Shared types and width helpers for the sequential vector        |
// |            driver: run state encoding, packed stimulus vector layout.      |
// | Ports    : none (package)                                                  |
// | Options  : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package seq_drv_pkg;

  // Run state; explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_DATA_W = 8;
  // exp, d and c are single bits stacked above the two operands.
  localparam int CTRL_W     = 3;

  // Table entry layout at the default operand width; exp is the MSB.
  typedef struct packed {
    logic                  exp;
    logic                  d;
    logic                  c;
    logic [DEF_DATA_W-1:0] b;
    logic [DEF_DATA_W-1:0] a;
  } vec_t;

  // Packed entry width for an arbitrary operand width.
  function automatic int vec_width(input int data_w);
    return 2 * data_w + CTRL_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_vector_driver_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_vector_driver_if                                            |
// | Purpose  : Bundles the table-load/control inputs, the stimulus bus to the  |
// |            datapath under test, the result return and the status outputs. |
// | Ports    : wr_en_i/wr_addr_i/wr_data_i table load, start_i run request,    |
// |            loop_i (SEQ_DRV_LOOP_EN only), a_o/b_o/c_o/d_o stimulus,        |
// |            res_i result, busy_o/done_o/pass_o/err_cnt_o/fail_idx_o status. |
// |            master = driver side, slave = environment side.                |
// | Options  : SEQ_DRV_LOOP_EN adds loop_i                                    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface seq_vector_driver_if #(
  parameter int DATA_W  = 8,
  parameter int VEC_NUM = 8,
  parameter int ERR_W   = 8
);
  localparam int IDX_W = $clog2(VEC_NUM);

  logic                  wr_en_i;
  logic [IDX_W-1:0]      wr_addr_i;
  logic [2*DATA_W+2:0]   wr_data_i;
  logic                  start_i;
`ifdef SEQ_DRV_LOOP_EN
  logic                  loop_i;
`endif
  logic [DATA_W-1:0]     a_o;
  logic [DATA_W-1:0]     b_o;
  logic                  c_o;
  logic                  d_o;
  logic                  res_i;
  logic                  busy_o;
  logic                  done_o;
  logic                  pass_o;
  logic [ERR_W-1:0]      err_cnt_o;
  logic [IDX_W-1:0]      fail_idx_o;

`ifdef SEQ_DRV_LOOP_EN
  modport master (
    input  wr_en_i, wr_addr_i, wr_data_i, start_i, loop_i, res_i,
    output a_o, b_o, c_o, d_o, busy_o, done_o, pass_o, err_cnt_o, fail_idx_o
  );
  modport slave (
    output wr_en_i, wr_addr_i, wr_data_i, start_i, loop_i, res_i,
    input  a_o, b_o, c_o, d_o, busy_o, done_o, pass_o, err_cnt_o, fail_idx_o
  );
`else
  modport master (
    input  wr_en_i, wr_addr_i, wr_data_i, start_i, res_i,
    output a_o, b_o, c_o, d_o, busy_o, done_o, pass_o, err_cnt_o, fail_idx_o
  );
  modport slave (
    output wr_en_i, wr_addr_i, wr_data_i, start_i, res_i,
    input  a_o, b_o, c_o, d_o, busy_o, done_o, pass_o, err_cnt_o, fail_idx_o
  );
`endif

endinterface
`default_nettype wire

// File: rtl/seq_drv_dly.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_drv_dly                                                     |
// | Purpose  : LAT-deep shift register carrying {valid, exp, idx} from the     |
// |            drive point to the compare point.                               |
// | Ports    : clk clock, clr synchronous clear, din entry in, dout entry out. |
// | Options  : none                                                            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seq_drv_dly #(
  parameter int LAT   = 1,
  parameter int IDX_W = 3
) (
  input  wire logic             clk,
  input  wire logic             clr,
  input  wire logic [IDX_W+1:0] din,
  output logic      [IDX_W+1:0] dout
);

  logic [IDX_W+1:0] stage [LAT];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[LAT-1];

endmodule
`default_nettype wire

// File: rtl/seq_vector_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_vector_driver                                               |
// | Purpose  : On-board self-test driver: plays a table of {a,b,c,d} vectors   |
// |            into a datapath one per cycle, compares the result LAT cycles   |
// |            later with the stored expectation, reports pass/fail, a         |
// |            saturating error count and the first failing index.            |
// | Ports    : clk_i clock, srst_i synchronous active-high reset,              |
// |            bus (seq_vector_driver_if.master) load/control/stimulus/status. |
// | Options  : SEQ_DRV_LOOP_EN - loop_i repeats the table without a gap.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module seq_vector_driver
  import seq_drv_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int VEC_NUM = 8,
  parameter int LAT     = 1,
  parameter int ERR_W   = 8
) (
  input wire logic      clk_i,
  input wire logic      srst_i,
  seq_vector_driver_if.master bus
);

  localparam int IDX_W = $clog2(VEC_NUM);
  localparam int VW    = vec_width(DATA_W);
  localparam int DRN_W = $clog2(LAT + 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_NUM - 1);
  localparam logic [DRN_W-1:0] DRN_END  = DRN_W'(LAT);

  logic [VW-1:0]    vec_tab [VEC_NUM];
  state_t           state;
  logic [IDX_W-1:0] idx;          // next table entry to present
  logic [DRN_W-1:0] drain_cnt;
  logic [VW-1:0]    out_vec;      // currently presented vector, incl. exp
  logic             cur_valid;
  logic [IDX_W-1:0] cur_idx;
  logic [ERR_W-1:0] err_cnt;
  logic [IDX_W-1:0] fail_idx;
  logic             busy, done, pass;

  logic             write_ok, loop_req, mismatch;
  logic [VW-1:0]    drive_vec;
  logic [IDX_W-1:0] load_idx;
  logic [IDX_W+1:0] cmp_entry;
  logic [ERR_W-1:0] err_next;

`ifdef SEQ_DRV_LOOP_EN
  assign loop_req = bus.loop_i;
`else
  assign loop_req = 1'b0;
`endif

  assign write_ok = bus.wr_en_i && (state == IDLE || state == DONE);

  // The start cycle presents entry 0; a write to entry 0 in that same cycle
  // is forwarded so the run sees the new data.
  always_comb begin
    drive_vec = vec_tab[idx];
    load_idx  = idx;
    if (state != DRIVE) begin
      load_idx  = '0;
      drive_vec = vec_tab[0];
      if (write_ok && bus.wr_addr_i == '0) drive_vec = bus.wr_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (write_ok) vec_tab[bus.wr_addr_i] <= bus.wr_data_i;
  end

  // The entry register cur_* sits alongside the output register, so the
  // delay line output lines up with res_i exactly LAT cycles after a vector
  // first appears on the outputs.
  seq_drv_dly #(.LAT(LAT), .IDX_W(IDX_W)) u_dly (
    .clk  (clk_i),
    .clr  (srst_i),
    .din  ({cur_valid, out_vec[VW-1], cur_idx}),
    .dout (cmp_entry)
  );

  assign mismatch = cmp_entry[IDX_W+1] && (cmp_entry[IDX_W] != bus.res_i);
  assign err_next = (mismatch && err_cnt != ERR_MAX) ? err_cnt + 1'b1 : err_cnt;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state     <= IDLE;
      idx       <= '0;
      drain_cnt <= '0;
      out_vec   <= '0;
      cur_valid <= 1'b0;
      cur_idx   <= '0;
      err_cnt   <= '0;
      fail_idx  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      err_cnt   <= err_next;
      // A zero count means no mismatch has been seen yet this run.
      if (mismatch && err_cnt == '0) fail_idx <= cmp_entry[IDX_W-1:0];
      cur_valid <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (bus.start_i) begin
            state     <= DRIVE;
            out_vec   <= drive_vec;
            cur_valid <= 1'b1;
            cur_idx   <= load_idx;
            idx       <= IDX_W'(1);
            err_cnt   <= '0;
            fail_idx  <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
          end
        end
        DRIVE: begin
          out_vec   <= drive_vec;
          cur_valid <= 1'b1;
          cur_idx   <= load_idx;
          idx       <= idx + 1'b1;   // power-of-two table wraps to 0
          if (idx == LAST_IDX && !loop_req) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRN_END) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a_o        = out_vec[DATA_W-1:0];
  assign bus.b_o        = out_vec[2*DATA_W-1:DATA_W];
  assign bus.c_o        = out_vec[2*DATA_W];
  assign bus.d_o        = out_vec[2*DATA_W+1];
  assign bus.busy_o     = busy;
  assign bus.done_o     = done;
  assign bus.pass_o     = pass;
  assign bus.err_cnt_o  = err_cnt;
  assign bus.fail_idx_o = fail_idx;

endmodule
`default_nettype wire

// File: tb/tb_seq_vector_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seq_vector_driver                                            |
// | Purpose  : Self-checking bench for seq_vector_driver with a behavioural    |
// |            datapath stand-in and a table-level expected-result model.      |
// | Ports    : none                                                            |
// | Options  : SEQ_DRV_LOOP_EN enables the loop scenario                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_seq_vector_driver;
  import seq_drv_pkg::*;

  localparam int DATA_W  = 8;
  localparam int VEC_NUM = 8;
  localparam int LAT     = 2;
  localparam int ERR_W   = 2;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic clk = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  seq_vector_driver_if #(.DATA_W(DATA_W), .VEC_NUM(VEC_NUM), .ERR_W(ERR_W)) bus ();

  seq_vector_driver #(.DATA_W(DATA_W), .VEC_NUM(VEC_NUM), .LAT(LAT), .ERR_W(ERR_W)) dut (
    .clk_i  (clk),
    .srst_i (srst),
    .bus    (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] ta [VEC_NUM];
  logic [7:0] tb_ [VEC_NUM];
  logic       tc [VEC_NUM];
  logic       td [VEC_NUM];
  logic       te [VEC_NUM];

  // Datapath stand-in: the function it computes, LAT cycles late.
  function automatic logic dp_func(input logic [7:0] a, input logic [7:0] b,
                                   input logic c, input logic d);
    if (c)      return a < b;
    else if (d) return a > b;
    else        return a == b;
  endfunction

  logic [LAT-1:0] res_pipe = '0;
  always @(posedge clk) res_pipe <= {res_pipe[LAT-2:0], dp_func(bus.a_o, bus.b_o, bus.c_o, bus.d_o)};
  assign bus.res_i = res_pipe[LAT-1];

  // Expected outcome of a run over the table, repeated for 'passes' passes.
  function automatic void model(input int passes, output int err, output int fidx);
    int cnt = 0;
    fidx = 0;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < VEC_NUM; i++)
        if (dp_func(ta[i], tb_[i], tc[i], td[i]) != te[i]) begin
          if (cnt == 0) fidx = i;
          cnt++;
        end
    err = (cnt > ERR_MAX) ? ERR_MAX : cnt;
  endfunction

  function automatic logic [2*DATA_W+2:0] pack(input int i);
    vec_t v;
    v.exp = te[i]; v.d = td[i]; v.c = tc[i]; v.b = tb_[i]; v.a = ta[i];
    return v;
  endfunction

  task automatic fill_random(input int corrupt_pct);
    for (int i = 0; i < VEC_NUM; i++) begin
      ta[i]  = 8'($urandom);
      tb_[i] = ($urandom_range(0, 3) == 0) ? ta[i] : 8'($urandom);
      tc[i]  = 1'($urandom);
      td[i]  = 1'($urandom);
      te[i]  = dp_func(ta[i], tb_[i], tc[i], td[i]) ^ ($urandom_range(0, 99) < corrupt_pct);
    end
  endtask

  task automatic load_table();
    for (int i = 0; i < VEC_NUM; i++) begin
      @(negedge clk);
      bus.wr_en_i = 1'b1; bus.wr_addr_i = 3'(i); bus.wr_data_i = pack(i);
    end
    @(negedge clk);
    bus.wr_en_i = 1'b0;
  endtask

  // Start a run, check every driven vector, done timing and final status.
  // poke_cyc >= 0 fires start_i plus a table write mid-run (must be ignored).
  // wr0 writes entry 0 in the same cycle as start_i.
  task automatic run_check(input string name, input int passes, input int poke_cyc, input bit wr0);
    int err_e, fidx_e, cyc, k;
    bit seen;
    model(passes, err_e, fidx_e);
    @(negedge clk);
    bus.start_i = 1'b1;
    if (wr0) begin bus.wr_en_i = 1'b1; bus.wr_addr_i = '0; bus.wr_data_i = pack(0); end
`ifdef SEQ_DRV_LOOP_EN
    bus.loop_i = (passes > 1);
`endif
    @(negedge clk);
    bus.start_i = 1'b0; bus.wr_en_i = 1'b0;
    seen = 1'b0;
    for (cyc = 0; cyc < 200; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (bus.done_o) begin seen = 1'b1; break; end
      if (cyc == 0) begin
        vectors++;
        if (bus.busy_o !== 1'b1) begin
          miscompares++; $display("FAIL %s busy: got %b want 1", name, bus.busy_o);
        end
      end
      if (cyc < passes * VEC_NUM) begin
        k = cyc % VEC_NUM;
        vectors++;
        if ({bus.a_o, bus.b_o, bus.c_o, bus.d_o} !== {ta[k], tb_[k], tc[k], td[k]}) begin
          miscompares++;
          $display("FAIL %s vec cyc%0d: got %h_%h_%b_%b want %h_%h_%b_%b", name, cyc,
                   bus.a_o, bus.b_o, bus.c_o, bus.d_o, ta[k], tb_[k], tc[k], td[k]);
        end
`ifdef SEQ_DRV_LOOP_EN
        bus.loop_i = (cyc + 1 < (passes - 1) * VEC_NUM);
`endif
      end
      if (cyc == poke_cyc) begin
        bus.start_i = 1'b1; bus.wr_en_i = 1'b1; bus.wr_addr_i = 3'd6; bus.wr_data_i = ~pack(6);
      end else if (cyc == poke_cyc + 1) begin
        bus.start_i = 1'b0; bus.wr_en_i = 1'b0;
      end
    end
    vectors++;
    if (!seen || cyc != passes * VEC_NUM + LAT) begin
      miscompares++;
      $display("FAIL %s done_time: got %0d (seen=%b) want %0d", name, cyc, seen, passes * VEC_NUM + LAT);
    end
    vectors++;
    if (bus.err_cnt_o !== ERR_W'(err_e)) begin
      miscompares++; $display("FAIL %s err_cnt: got %0d want %0d", name, bus.err_cnt_o, err_e);
    end
    vectors++;
    if (bus.fail_idx_o !== 3'(fidx_e)) begin
      miscompares++; $display("FAIL %s fail_idx: got %0d want %0d", name, bus.fail_idx_o, fidx_e);
    end
    vectors++;
    if (bus.pass_o !== (err_e == 0)) begin
      miscompares++; $display("FAIL %s pass: got %b want %b", name, bus.pass_o, err_e == 0);
    end
    vectors++;
    if (bus.busy_o !== 1'b0) begin
      miscompares++; $display("FAIL %s busy_end: got %b want 0", name, bus.busy_o);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if ({bus.a_o, bus.b_o, bus.c_o, bus.d_o} !== '0) begin
      miscompares++; $display("FAIL %s abcd: got %h want 0", name, {bus.a_o, bus.b_o, bus.c_o, bus.d_o});
    end
    vectors++;
    if ({bus.busy_o, bus.done_o, bus.pass_o} !== 3'b000) begin
      miscompares++; $display("FAIL %s busy/done/pass: got %b want 000", name, {bus.busy_o, bus.done_o, bus.pass_o});
    end
    vectors++;
    if ({bus.err_cnt_o, bus.fail_idx_o} !== '0) begin
      miscompares++; $display("FAIL %s err/fidx: got %0d/%0d want 0/0", name, bus.err_cnt_o, bus.fail_idx_o);
    end
  endtask

  task automatic test_reset();
    srst = 1'b1;
    repeat (2) @(negedge clk);
    srst = 1'b0;
    check_reset_outputs("reset");
  endtask

  task automatic test_pass();
    fill_random(0);
    ta[0] = 8'd1; tb_[0] = 8'd4; tc[0] = 1'b1; td[0] = 1'b0; te[0] = 1'b1;
    ta[1] = 8'd3; tb_[1] = 8'd6; tc[1] = 1'b0; td[1] = 1'b1; te[1] = 1'b0;
    load_table();
    run_check("pass", 1, -1, 1'b0);
  endtask

  task automatic test_mismatch();
    te[3] = ~te[3]; te[5] = ~te[5];
    load_table();
    run_check("mismatch", 1, -1, 1'b0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < VEC_NUM; i++) te[i] = ~dp_func(ta[i], tb_[i], tc[i], td[i]);
    load_table();
    run_check("saturate", 1, -1, 1'b0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      fill_random(30);
      load_table();
      run_check("random", 1, -1, 1'b0);
    end
  endtask

  task automatic test_write_with_start();
    ta[0] = ~ta[0]; te[0] = ~dp_func(ta[0], tb_[0], tc[0], td[0]);
    run_check("wr_start", 1, -1, 1'b1);
  endtask

  task automatic test_ignore();
    run_check("ignore", 1, 2, 1'b0);
    run_check("ignore_rerun", 1, -1, 1'b0);
  endtask

  task automatic test_abort();
    @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (4) @(negedge clk);
    vectors++;
    if (bus.a_o !== ta[4]) begin
      miscompares++; $display("FAIL abort_pre a: got %h want %h", bus.a_o, ta[4]);
    end
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    check_reset_outputs("abort");
    run_check("after_abort", 1, -1, 1'b0);
  endtask

`ifdef SEQ_DRV_LOOP_EN
  task automatic test_loop();
    for (int i = 0; i < VEC_NUM; i++) te[i] = dp_func(ta[i], tb_[i], tc[i], td[i]);
    te[2] = ~te[2];
    load_table();
    run_check("loop", 2, -1, 1'b0);
  endtask
`endif

  initial begin
    bus.wr_en_i = 1'b0; bus.wr_addr_i = '0; bus.wr_data_i = '0; bus.start_i = 1'b0;
`ifdef SEQ_DRV_LOOP_EN
    bus.loop_i = 1'b0;
`endif
    test_reset();
    test_pass();
    test_mismatch();
    test_saturation();
    test_random();
    test_write_with_start();
    test_ignore();
    test_abort();
`ifdef SEQ_DRV_LOOP_EN
    test_loop();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
